// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEF_W = 2;

  function automatic int cnt_w(input int w);
    return (2 * w > 1) ? $clog2(2 * w) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_w(DEF_W);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend
// bit, trial-subtract the divisor, keep the difference if no borrow.
module div_step
  import div_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W:0]   rem,
  input  logic         dvd_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // rem never exceeds the divisor, so its top bit is zero and the
  // extra MSB of trial is the borrow.
  always_comb begin
    shifted  = {rem, dvd_bit};
    trial    = shifted - {2'b00, divisor};
    q_bit    = ~trial[W+1];
    rem_next = q_bit ? trial[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle,
// with valid/ready handshakes on the operand and result sides.
module restoring_divider
  import div_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = cnt_w(W);

  state_t         state;
  state_t         state_nx;
  logic [2*W-1:0] q;
  logic [W:0]     rem;
  logic [W-1:0]   dvs;
  logic [CW-1:0]  cnt;
  logic           dbz;
  logic [W:0]     rem_nx;
  logic           q_bit;

  div_step #(
    .W(W)
  ) u_step (
    .rem     (rem),
    .dvd_bit (q[2*W-1]),
    .divisor (dvs),
    .rem_next(rem_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_valid)
          state_nx = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The dividend shifts out of q's MSB while quotient bits enter its LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      dbz <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dvs <= divisor;
            rem <= '0;
            cnt <= CW'(2 * W - 1);
            if (divisor == '0) begin
              q   <= '1;
              dbz <= 1'b1;
            end else begin
              q   <= dividend;
              dbz <= 1'b0;
            end
          end
        end
        RUN: begin
          rem <= rem_nx;
          q   <= {q[2*W-2:0], q_bit};
          cnt <= cnt - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = q;
  assign remainder   = rem[W-1:0];
  assign div_by_zero = dbz;

endmodule
